// File: rtl/uart_tx_framer.sv
// Serial UART transmit framer: START, DATA_WIDTH bits LSB first, optional parity, STOP.
// TX_OUT/Busy are registered from the next-state decode so they change with the state.
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pen_q, pen_d;
  logic                  ptyp_q, ptyp_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    // Requests are only taken while the line is idle or sending the stop bit.
    if (Data_Valid && (state_q == IDLE || state_q == STOP)) begin
      data_d = P_DATA;
      pen_d  = PAR_EN;
      ptyp_d = PAR_TYP;
    end
    case (state_q)
      IDLE:    if (Data_Valid) state_d = START;
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST) begin
          state_d = pen_q ? PARITY : STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = Data_Valid ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state so the registered line tracks state_q.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      IDLE:    busy_d = 1'b0;
      START:   tx_d   = 1'b0;
      DATA:    tx_d   = data_d[cnt_d];
      PARITY:  tx_d   = (^data_d) ^ ptyp_d;
      STOP:    tx_d   = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench: a frame-level model queues the expected {Busy,TX_OUT} per cycle,
// a negedge monitor pops and compares.
module tb_uart_tx_framer;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          TX_OUT;
  logic          Busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [1:0] exp_q[$];
  logic       frm[$];

  uart_tx_framer #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Model: the line is free for a new frame when no bits remain after the current one.
  task automatic model_edge();
    logic [1:0] nxt;
    if (!RST) begin
      frm.delete();
    end else if (Data_Valid && frm.size() == 0) begin
      frm.push_back(1'b0);
      for (int i = 0; i < DW; i++) frm.push_back(P_DATA[i]);
      if (PAR_EN) begin
        int ones = 0;
        for (int i = 0; i < DW; i++) ones += P_DATA[i];
        frm.push_back((ones % 2 == 1) ^ PAR_TYP);
      end
      frm.push_back(1'b1);
    end
    if (frm.size() > 0) nxt = {1'b1, frm.pop_front()};
    else                nxt = 2'b01;
    exp_q.push_back(nxt);
  endtask

  task automatic cycle(input logic rst, input logic dv, input logic [DW-1:0] d,
                       input logic pen, input logic ptyp);
    RST = rst; Data_Valid = dv; P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp;
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b1, 1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
  endtask

  always @(negedge CLK) begin
    logic [1:0] e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({Busy, TX_OUT} !== e) begin
        errors++;
        $display("FAIL line cyc=%0d got Busy/TX=%b%b want %b%b", cyc, Busy, TX_OUT, e[1], e[0]);
      end
    end
  end

  initial begin
    #1;
    // Reset with a request pending: must be ignored.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    idle(5);
    cycle(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0); idle(12);
    cycle(1'b1, 1'b1, 8'h07, 1'b1, 1'b0); idle(12);
    cycle(1'b1, 1'b1, 8'h07, 1'b1, 1'b1); idle(12);
    // Back-to-back with Data_Valid held high.
    cycle(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) cycle(1'b1, 1'b1, 8'h0F, 1'b0, 1'b0);
    idle(12);
    // Mid-frame pulses must not disturb the frame.
    cycle(1'b1, 1'b1, 8'h96, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, i[0], DW'($urandom), 1'($urandom), 1'($urandom));
    idle(12);
    // Reset during DATA bit 4 of 0xFF.
    cycle(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    idle(5);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(2);
    cycle(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0); idle(14);
    // Live inputs toggling during a 0x3C frame.
    cycle(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++)
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
            DW'($urandom), 1'($urandom), 1'($urandom));
    idle(14);
    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter: DATA_WIDTH, 8, payload bits per frame (legal range 5-8).
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  reset, synchronous, active-low; one clock; reset is synchronous and active-low.
REQ-004 Port: P_DATA  input  DATA_WIDTH  parallel payload; sampled only on an accepted request.
REQ-005 Port: Data_Valid  input  1  transmit request; accepted only in IDLE or STOP.
REQ-006 Port: PAR_EN  input  1  1 = insert parity bit; sampled with P_DATA.
REQ-007 Port: PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled with P_DATA.
REQ-008 Port: TX_OUT  output  1  registered serial line; idle/mark level 1.
REQ-009 Port: Busy  output  1  registered; 1 while a frame occupies the line.

Function
REQ-010 The block SHALL serialize one bit per CLK cycle; a frame SHALL be START(0), DATA_WIDTH data bits LSB first, optional PARITY, STOP(1).
REQ-011 The state machine SHALL have exactly five states: IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE: TX_OUT=1, Busy=0; Data_Valid=1 at an edge SHALL capture P_DATA, PAR_EN, PAR_TYP into internal registers and move to START.
REQ-013 START: TX_OUT=0, Busy=1, for one cycle; SHALL then move to DATA with bit counter=0.
REQ-014 DATA: TX_OUT=captured bit[counter], Busy=1; counter SHALL increment each cycle; after counter=DATA_WIDTH-1 SHALL move to PARITY if captured PAR_EN=1, else STOP.
REQ-015 PARITY: TX_OUT = XOR-reduce(captured data) XOR captured PAR_TYP, Busy=1, one cycle, then STOP.
REQ-016 Parity SHALL be computed from the captured payload, never from live P_DATA.
REQ-017 STOP: TX_OUT=1, Busy=1, one cycle; at the next edge SHALL move to START (capturing new inputs) if Data_Valid=1, else IDLE.
REQ-018 Latency: TX_OUT SHALL show the start bit in the cycle immediately after the accepting edge; Busy SHALL rise in that same cycle.
REQ-019 Frame length (Busy-high cycles) SHALL be DATA_WIDTH+2 without parity, DATA_WIDTH+3 with parity.
REQ-020 Data_Valid in START, DATA or PARITY SHALL be ignored with no effect on the frame or captured registers.
REQ-021 Back-to-back requests via STOP SHALL produce no idle cycle between frames; Busy SHALL stay 1 throughout.
REQ-022 Changes on P_DATA, PAR_EN, PAR_TYP during a frame SHALL NOT alter the frame in progress.
REQ-023 TX_OUT and Busy SHALL be driven directly from flip-flops (no combinational path from inputs).
REQ-024 Bit counter width SHALL be ceil(log2(DATA_WIDTH)); counter SHALL reset to 0 on every DATA entry.

Reset
REQ-025 With RST=0 at a rising edge: state=IDLE, TX_OUT=1, Busy=0, counter=0, captured data/config=0.
REQ-026 Reset asserted mid-frame SHALL abort it at that edge; line returns to 1 with no partial stop bit.
REQ-027 Data_Valid=1 in the same cycle as RST=0 SHALL be ignored; the first acceptance is possible at the first edge with RST=1.

Verification
REQ-028 Reset then idle 5 cycles -> TX_OUT=1, Busy=0 every cycle.
REQ-029 P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1; Busy high 10 cycles, then IDLE.
REQ-030 P_DATA=0x07, PAR_EN=1, PAR_TYP=0 -> parity bit 1; same with PAR_TYP=1 -> parity bit 0; Busy high 11 cycles.
REQ-031 Data_Valid held high, P_DATA=0x55 then 0x0F -> second start bit in the cycle after first stop bit; Busy never drops; Data_Valid pulses mid-frame ignored.
REQ-032 RST=0 during DATA bit 4 of 0xFF frame -> next cycle TX_OUT=1, Busy=0; new request after reset transmits full correct frame.
REQ-033 P_DATA toggled every cycle during a 0x3C frame -> transmitted bits match 0x3C LSB first and parity of 0x3C.
